// File: rtl/rv32i_pkg.sv
// rv32i_pkg -- shared definitions for the instruction fetch slice.
//   NS_*              : encodings of the next_sel control-transfer field
//   fetch_state_e     : fetch state machine states (REQ, WAIT, HOLD)
//   DEFAULT_RESET_PC  : default first fetch address after reset
//   redirect_kind_taken() : does a transfer kind actually change the PC
package rv32i_pkg;

  localparam logic [1:0] NS_SEQ  = 2'b00;
  localparam logic [1:0] NS_JALR = 2'b01;
  localparam logic [1:0] NS_JAL  = 2'b10;
  localparam logic [1:0] NS_BR   = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // Sequential flow never redirects; jal/jalr always do; a branch only
  // redirects when its outcome is taken.
  function automatic logic redirect_kind_taken(input logic [1:0] kind,
                                               input logic       taken);
    logic result;
    result = 1'b0;
    case (kind)
      NS_SEQ:  result = 1'b0;
      NS_JALR: result = 1'b1;
      NS_JAL:  result = 1'b1;
      NS_BR:   result = taken;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// fetch_pc_sel -- combinational redirect decision.
//   redirect_valid : a control transfer is resolved this cycle
//   next_sel       : transfer kind (seq / jalr / jal / branch)
//   branch_taken   : branch outcome, only meaningful for a branch
//   target_pc      : computed transfer target
//   redirect_take  : the fetch stream must be redirected this cycle
//   redirect_pc    : word-aligned new fetch address
//   redirect_misal : target had bit 1 set (after the jalr bit-0 mask)
module fetch_pc_sel
  import rv32i_pkg::*;
(
  input  logic        redirect_valid,
  input  logic [1:0]  next_sel,
  input  logic        branch_taken,
  input  logic [31:0] target_pc,
  output logic        redirect_take,
  output logic [31:0] redirect_pc,
  output logic        redirect_misal
);

  logic [31:0] masked_target;
  logic        unused_lsb;

  always_comb begin
    masked_target = target_pc;
    // jalr clears bit 0 of the computed sum before use.
    if (next_sel == NS_JALR) begin
      masked_target = {target_pc[31:1], 1'b0};
    end
  end

  assign redirect_take  = redirect_valid & redirect_kind_taken(next_sel, branch_taken);
  // Fetch only ever issues word addresses; the low two bits are dropped.
  assign redirect_pc    = {masked_target[31:2], 2'b00};
  assign redirect_misal = redirect_take & masked_target[1];

  // Bit 0 is discarded by the word alignment for every transfer kind.
  assign unused_lsb = masked_target[0];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- single-outstanding instruction fetch with redirect support.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   imem_req/addr/gnt           : request channel to instruction memory
//   imem_rvalid/rdata           : response channel from instruction memory
//   id_valid/ready/instr/pc     : held instruction handed to decode
//   opcode/func3/func7          : instruction fields for the control unit
//   redirect_valid, next_sel,
//   branch_taken, target_pc     : control-transfer resolution from execute
//   misalign_err                : one-cycle pulse for a bit-1 misaligned target
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic        func7,
  input  logic        redirect_valid,
  input  logic [1:0]  next_sel,
  input  logic        branch_taken,
  input  logic [31:0] target_pc,
  output logic        misalign_err
);

  fetch_state_e state_reg;
  logic [31:0]  fetch_pc_reg;
  logic [31:0]  req_pc_reg;
  logic [31:0]  id_instr_reg;
  logic [31:0]  id_pc_reg;
  logic         id_valid_reg;
  logic         flush_pending_reg;
  logic         misalign_reg;

  logic         redirect_take;
  logic [31:0]  redirect_pc;
  logic         redirect_misal;

  fetch_pc_sel u_fetch_pc_sel (
    .redirect_valid (redirect_valid),
    .next_sel       (next_sel),
    .branch_taken   (branch_taken),
    .target_pc      (target_pc),
    .redirect_take  (redirect_take),
    .redirect_pc    (redirect_pc),
    .redirect_misal (redirect_misal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= ST_REQ;
      fetch_pc_reg      <= RESET_PC;
      req_pc_reg        <= 32'h0;
      id_instr_reg      <= 32'h0;
      id_pc_reg         <= 32'h0;
      id_valid_reg      <= 1'b0;
      flush_pending_reg <= 1'b0;
      misalign_reg      <= 1'b0;
    end else begin
      misalign_reg <= redirect_misal;

      case (state_reg)
        ST_REQ: begin
          if (imem_gnt) begin
            req_pc_reg   <= fetch_pc_reg;
            fetch_pc_reg <= fetch_pc_reg + 32'd4;
            // A redirect in the grant cycle makes the just-issued fetch stale.
            flush_pending_reg <= redirect_take;
            state_reg         <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (imem_rvalid) begin
            if (flush_pending_reg || redirect_take) begin
              // Stale response: consume it and refetch from the new PC.
              flush_pending_reg <= 1'b0;
              state_reg         <= ST_REQ;
            end else begin
              id_instr_reg <= imem_rdata;
              id_pc_reg    <= req_pc_reg;
              id_valid_reg <= 1'b1;
              state_reg    <= ST_HOLD;
            end
          end else if (redirect_take) begin
            // Response still in flight; remember to drop it when it lands.
            flush_pending_reg <= 1'b1;
          end
        end

        ST_HOLD: begin
          // A redirect squashes the held word even if decode is ready.
          if (redirect_take || id_ready) begin
            id_valid_reg <= 1'b0;
            state_reg    <= ST_REQ;
          end
        end

        default: begin
          state_reg <= ST_REQ;
        end
      endcase

      // Redirect overrides the sequential increment in every state.
      if (redirect_take) begin
        fetch_pc_reg <= redirect_pc;
      end
    end
  end

  // Gated by rst_n so no request is presented while reset is held.
  assign imem_req     = rst_n & (state_reg == ST_REQ);
  assign imem_addr    = fetch_pc_reg;
  assign id_valid     = id_valid_reg;
  assign id_instr     = id_instr_reg;
  assign id_pc        = id_pc_reg;
  assign opcode       = id_instr_reg[6:0];
  assign func3        = id_instr_reg[14:12];
  assign func7        = id_instr_reg[30];
  assign misalign_err = misalign_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed checks followed by a randomized run against a
// transaction-level model of the fetch stream (expected PC sequence,
// memory contents, redirect targets and misalign pulses).
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        func7;
  logic        redirect_valid;
  logic [1:0]  next_sel;
  logic        branch_taken;
  logic [31:0] target_pc;
  logic        misalign_err;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .opcode         (opcode),
    .func3          (func3),
    .func7          (func7),
    .redirect_valid (redirect_valid),
    .next_sel       (next_sel),
    .branch_taken   (branch_taken),
    .target_pc      (target_pc),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; outputs are sampled and
  // inputs for the new cycle are driven from here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    next_sel       = 2'b00;
    branch_taken   = 1'b0;
    target_pc      = 32'h0;
  endtask

  task automatic redirect(input logic [1:0] kind, input logic taken, input logic [31:0] tgt);
    redirect_valid = 1'b1;
    next_sel       = kind;
    branch_taken   = taken;
    target_pc      = tgt;
  endtask

  // Contents of the modelled instruction memory.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
  endfunction

  // Randomized-run model state
  logic [31:0] exp_pc;
  logic        exp_mis;
  logic        exp_mis_next;
  logic        pending;
  logic [31:0] pend_addr;
  int          delay;
  int          delivered;
  logic        eff;

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) next_cycle();

    // Reset state
    chk1("rst_imem_req", imem_req, 1'b0);
    chk1("rst_id_valid", id_valid, 1'b0);
    chk1("rst_misalign", misalign_err, 1'b0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);

    // Release: request in the first cycle, immediate grant, rvalid +1
    rst_n = 1'b1;
    #1;
    chk1("c0_imem_req", imem_req, 1'b1);
    chk("c0_imem_addr", imem_addr, 32'h0);
    imem_gnt = 1'b1;
    next_cycle();
    chk1("c1_imem_req", imem_req, 1'b0);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00A0_0093;
    next_cycle();
    imem_rvalid = 1'b0;
    chk1("c2_id_valid", id_valid, 1'b1);
    chk("c2_id_pc", id_pc, 32'h0);
    chk("c2_id_instr", id_instr, 32'h00A0_0093);
    chk("c2_opcode", 32'(opcode), 32'h13);
    chk("c2_func3", 32'(func3), 32'h0);
    chk1("c2_func7", func7, 1'b0);

    // Decode stalls for 5 cycles
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      chk1("hold_id_valid", id_valid, 1'b1);
      chk("hold_id_instr", id_instr, 32'h00A0_0093);
      chk("hold_id_pc", id_pc, 32'h0);
      chk1("hold_no_req", imem_req, 1'b0);
    end
    id_ready = 1'b1;
    next_cycle();
    id_ready = 1'b0;
    chk1("rel_id_valid", id_valid, 1'b0);
    chk1("rel_imem_req", imem_req, 1'b1);
    chk("rel_imem_addr", imem_addr, 32'h4);

    // jal redirect while waiting: stale word dropped
    imem_gnt = 1'b1;
    next_cycle();
    imem_gnt = 1'b0;
    redirect(2'b10, 1'b0, 32'h100);
    next_cycle();
    clear_inputs();
    chk1("jw_still_wait", imem_req, 1'b0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    next_cycle();
    imem_rvalid = 1'b0;
    chk1("jw_no_stale_valid", id_valid, 1'b0);
    chk1("jw_imem_req", imem_req, 1'b1);
    chk("jw_imem_addr", imem_addr, 32'h100);
    imem_gnt = 1'b1;
    next_cycle();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h4020_80B3;
    next_cycle();
    imem_rvalid = 1'b0;
    chk1("jw_new_valid", id_valid, 1'b1);
    chk("jw_new_pc", id_pc, 32'h100);
    chk("jw_new_opcode", 32'(opcode), 32'h33);
    chk1("jw_new_func7", func7, 1'b1);

    // Untaken branch in HOLD is ignored; taken branch squashes
    redirect(2'b11, 1'b0, 32'h40);
    next_cycle();
    chk1("bnt_id_valid", id_valid, 1'b1);
    chk("bnt_id_pc", id_pc, 32'h100);
    redirect(2'b11, 1'b1, 32'h40);
    id_ready = 1'b1;
    next_cycle();
    clear_inputs();
    chk1("bt_id_valid", id_valid, 1'b0);
    chk1("bt_imem_req", imem_req, 1'b1);
    chk("bt_imem_addr", imem_addr, 32'h40);
    chk1("bt_misalign", misalign_err, 1'b0);

    // jalr targets in REQ without grant
    redirect(2'b01, 1'b0, 32'h203);
    next_cycle();
    clear_inputs();
    chk("jalr203_addr", imem_addr, 32'h200);
    redirect(2'b01, 1'b0, 32'h201);
    next_cycle();
    clear_inputs();
    chk("jalr201_addr", imem_addr, 32'h200);
    chk1("jalr201_misalign", misalign_err, 1'b0);
    redirect(2'b01, 1'b0, 32'h206);
    next_cycle();
    clear_inputs();
    chk("jalr206_addr", imem_addr, 32'h204);
    chk1("jalr206_misalign", misalign_err, 1'b1);
    next_cycle();
    chk1("jalr206_pulse_end", misalign_err, 1'b0);
    chk1("jalr206_req", imem_req, 1'b1);

    // Address wrap at the top of the space
    redirect(2'b10, 1'b0, 32'hFFFF_FFFC);
    next_cycle();
    clear_inputs();
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    imem_gnt = 1'b1;
    next_cycle();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0013;
    next_cycle();
    imem_rvalid = 1'b0;
    chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    id_ready = 1'b1;
    next_cycle();
    id_ready = 1'b0;
    chk("wrap_addr_zero", imem_addr, 32'h0);

    // Reset while waiting; late response afterwards is ignored
    imem_gnt = 1'b1;
    next_cycle();
    imem_gnt = 1'b0;
    chk1("rw_wait", imem_req, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("rw_rst_req", imem_req, 1'b0);
    chk1("rw_rst_valid", id_valid, 1'b0);
    next_cycle();
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hFFFF_FFFF;
    #1;
    chk1("rw_rel_req", imem_req, 1'b1);
    next_cycle();
    imem_rvalid = 1'b0;
    chk1("rw_late_ignored", id_valid, 1'b0);
    chk1("rw_restart_req", imem_req, 1'b1);
    chk("rw_restart_addr", imem_addr, 32'h0);

    // Randomized run against the fetch-stream model
    clear_inputs();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    #1;
    exp_pc    = 32'h0;
    exp_mis   = 1'b0;
    pending   = 1'b0;
    pend_addr = 32'h0;
    delay     = 0;
    delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk1("r_misalign", misalign_err, exp_mis);
      if (pending) chk1("r_one_outstanding", imem_req, 1'b0);
      if (imem_req) chk("r_addr_align", 32'(imem_addr[1:0]), 32'h0);
      if (id_valid) begin
        chk("r_id_pc", id_pc, exp_pc);
        chk("r_id_instr", id_instr, mem_word(exp_pc));
      end

      clear_inputs();
      if (pending) begin
        if (delay == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pending     = 1'b0;
        end else begin
          delay--;
        end
      end else begin
        if ($urandom_range(0, 9) == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = ~mem_word(imem_addr);
        end
        if (imem_req && ($urandom_range(0, 1) == 1)) begin
          imem_gnt  = 1'b1;
          pending   = 1'b1;
          pend_addr = imem_addr;
          delay     = int'($urandom_range(0, 3));
        end
      end

      id_ready     = ($urandom_range(0, 9) < 6);
      next_sel     = 2'($urandom_range(0, 3));
      branch_taken = 1'($urandom_range(0, 1));
      target_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : 32'($urandom_range(0, 4095));
      redirect_valid = ($urandom_range(0, 9) == 0);

      eff = redirect_valid && ((next_sel == 2'b01) || (next_sel == 2'b10) ||
                               ((next_sel == 2'b11) && branch_taken));
      if (id_valid && id_ready && !eff) begin
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (eff) exp_pc = {target_pc[31:2], 2'b00};
      exp_mis_next = eff && target_pc[1];

      next_cycle();
      exp_mis = exp_mis_next;
    end
    chk1("r_progress", delivered > 100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
